// File: rtl/ram_arbiter.sv
// Two-port arbiter and access sequencer for a single-port word-wide RAM.
// Partial-byte writes become read-modify-write sequences; one transaction in flight.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter bit RR_ENABLE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [31:0]           req0_wdata,
    input  logic [3:0]            req0_wstrb,
    output logic                  resp0_valid,
    output logic [31:0]           resp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [31:0]           req1_wdata,
    input  logic [3:0]            req1_wstrb,
    output logic                  resp1_valid,
    output logic [31:0]           resp1_rdata,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_mem_read,
    output logic                  ram_mem_write,
    output logic [31:0]           ram_data_in,
    input  logic [31:0]           ram_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        RESP
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    state_t                  state_reg;
    state_t                  state_next;
    logic                    last_grant_reg;
    logic                    port_reg;
    logic                    write_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [31:0]             wdata_reg;
    logic [3:0]              wstrb_reg;
    logic [31:0]             data_in_reg;
    logic [31:0]             rdata_reg;

    logic                    grant0;
    logic                    grant1;
    logic                    accept;
    logic                    sel_port;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [31:0]             sel_wdata;
    logic [3:0]              sel_wstrb;
    logic [31:0]             merged_word;

    // Port 0 wins when it is alone, when priority is fixed, or when port 1 had the last grant.
    assign grant0 = req0_valid && (!req1_valid || !RR_ENABLE || last_grant_reg);
    assign grant1 = req1_valid && !grant0;

    assign req0_ready = (state_reg == IDLE) && grant0;
    assign req1_ready = (state_reg == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;

    assign sel_port  = grant1;
    assign sel_write = grant1 ? req1_write : req0_write;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
    assign sel_wstrb = grant1 ? req1_wstrb : req0_wstrb;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = wstrb_reg[gi] ? wdata_reg[8*gi +: 8]
                                                          : ram_data_out[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!sel_write)
                        state_next = RD_ISSUE;
                    else if (&sel_wstrb)
                        state_next = WR_ISSUE;
                    else if (sel_wstrb == 4'b0000)
                        state_next = RESP;
                    else
                        state_next = RD_ISSUE;
                end
            end
            RD_ISSUE:   state_next = RD_CAPTURE;
            RD_CAPTURE: state_next = write_reg ? WR_ISSUE : RESP;
            WR_ISSUE:   state_next = RESP;
            RESP:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            port_reg       <= 1'b0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            data_in_reg    <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                last_grant_reg <= sel_port;
                port_reg       <= sel_port;
                write_reg      <= sel_write;
                addr_reg       <= sel_addr & ALIGN_MASK;
                wdata_reg      <= sel_wdata;
                wstrb_reg      <= sel_wstrb;
                if (sel_write && (&sel_wstrb))
                    data_in_reg <= sel_wdata;
            end
            // Captured word is either the read result or the base of a partial write.
            if (state_reg == RD_CAPTURE) begin
                if (write_reg)
                    data_in_reg <= merged_word;
                else
                    rdata_reg <= ram_data_out;
            end
        end
    end

    assign ram_address   = addr_reg;
    assign ram_data_in   = data_in_reg;
    assign ram_mem_read  = (state_reg == RD_ISSUE);
    assign ram_mem_write = (state_reg == WR_ISSUE);

    assign resp0_valid = (state_reg == RESP) && !port_reg;
    assign resp1_valid = (state_reg == RESP) &&  port_reg;
    assign resp0_rdata = (resp0_valid && !write_reg) ? rdata_reg : 32'h0;
    assign resp1_rdata = (resp1_valid && !write_reg) ? rdata_reg : 32'h0;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the single-port, word-wide data RAM. It shares the RAM between port 0 (CPU load/store unit) and port 1 (loader/debug master) using round-robin or fixed priority. It registers all RAM control signals and hides the RAM's one-cycle registered read latency. It also converts byte-masked writes into read-modify-write sequences, because the RAM has no byte enables.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of the requester and RAM byte addresses.
- RR_ENABLE, 1: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 always winning.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  port N (N=0,1) request valid.
- reqN_ready  out  1  port N request accepted this cycle.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- reqN_wdata  in  32  write data.
- reqN_wstrb  in  4  byte write mask; bit k covers bits [8k+7:8k].
- respN_valid  out  1  one-cycle completion pulse for port N.
- respN_rdata  out  32  read data, valid with respN_valid; 0 for writes.
- ram_address  out  ADDR_WIDTH  byte address to the RAM, forced word-aligned.
- ram_mem_read  out  1  RAM read strobe.
- ram_mem_write  out  1  RAM write strobe.
- ram_data_in  out  32  RAM write data.
- ram_data_out  in  32  RAM registered read data; 0 when the strobe was low.

## Operation
- FSM states:
  - IDLE
  - RD_ISSUE
  - RD_CAPTURE
  - WR_ISSUE
  - RESP
- Only one transaction is in flight at a time. reqN_ready is high only in IDLE, and only for the granted port.
- Grant rules in IDLE:
  - Only one port valid: that port is granted.
  - Both valid, RR_ENABLE=1: grant the port that was not `last_grant`.
  - Both valid, RR_ENABLE=0: grant port 0.
  - `last_grant` updates on every accept. Reset value is 1, so port 0 wins the first contention.
- On accept, latch the port id, write flag, {addr[31:2],2'b00}, wdata and wstrb.
- Next state after accept:
  - Read: RD_ISSUE.
  - Write with wstrb=4'b1111: WR_ISSUE.
  - Write with wstrb=4'b0000: RESP, with no RAM access.
  - Other write masks (partial write): RD_ISSUE, then read-modify-write.
- RD_ISSUE: ram_mem_read=1. Always goes to RD_CAPTURE.
- RD_CAPTURE:
  - Capture ram_data_out.
  - Read: store it as rdata, go to RESP.
  - Partial write: merge bytes (wstrb[k] ? wdata byte : captured byte), go to WR_ISSUE.
- WR_ISSUE: ram_mem_write=1, with ram_data_in set to the full or merged word. Goes to RESP.
- RESP: respN_valid=1 on the owning port only. respN_rdata is the captured word for reads and 0 for writes. Goes to IDLE.
- ram_mem_read and ram_mem_write are never high together.
- ram_address holds the latched address from RD_ISSUE through WR_ISSUE.
- The upper address bits are passed through unchanged; RAM-side wrap-around is the RAM's behaviour.
- There is no response backpressure: requesters must accept respN_valid when it pulses.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from req inputs to RAM outputs. The exception is reqN_ready, which is combinational from state and reqN_valid.
- Let T be the accept cycle (valid & ready high). The response pulse occurs at:
  - Read: T+3.
  - Full write: T+2, RAM written at the end of T+1.
  - Partial write: T+4, RAM read at T+1, written at the end of T+3.
  - wstrb=0 write: T+1.
- Throughput: a new request may be accepted in the cycle after RESP. Maximum back-to-back read rate is 1 per 4 cycles.
- Reset values (asynchronous):
  - state=IDLE, last_grant=1.
  - All ready and resp outputs 0.
  - ram_mem_read=0, ram_mem_write=0.
  - ram_address=0, ram_data_in=0, rdata=0.
- Reset mid-transaction aborts the transaction: no response, and the RAM strobes drop immediately.
- A requester dropping valid before ready has no effect. Once accepted, a transaction always completes.
- A requester changing addr or wdata after accept has no effect on the transaction.

## Test plan
- Port 0 full write: addr 0x40, wdata 0xDEADBEEF, wstrb 0xF.
  - resp0_valid at T+2, rdata 0.
  - A following read of 0x40 returns 0xDEADBEEF at T+3.
- Partial write to 0x40 holding 0xDEADBEEF, wstrb 0x2, wdata 0x0000AA00.
  - One ram_mem_read, then one ram_mem_write of 0xDEADAAEF.
  - resp at T+4.
- Both ports continuously issue reads, RR_ENABLE=1.
  - Grants alternate 0,1,0,1, starting with port 0 after reset.
  - resp1_valid is never asserted for a port 0 transaction.
- Same contention with RR_ENABLE=0: port 0 is granted every time and port 1 is never granted.
- Misaligned addr 0x43 read: ram_address=0x40. wstrb=0 write: resp at T+1 with no RAM strobe.
- Assert rst_n low during WR_ISSUE of a partial write.
  - ram_mem_write drops immediately and no resp is issued.
  - After release, the first request is accepted normally.
